regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file and successor to the single-write, dual-read GPR file.
- Provides two write ports (e.g. ALU and load/mult writeback), NREAD read ports with same-cycle write bypass, and a per-register busy scoreboard for multi-cycle producers.
- Runs a post-reset clearing sweep so all entries hold zero, not X, before the pipeline starts.
- Sits between the ID stage (reads) and the WB stage (writes).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width. DEPTH = 2**ADDR_W entries. Entry 0 is hardwired zero.
- NREAD, 2: number of read ports, 1..4.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; synchronous, active-high.
- init_done, output, 1: registered. High once the clearing sweep has finished.
- we0, input, 1: write enable, port 0.
- waddr0, input, ADDR_W: write address, port 0.
- wdata0, input, DATA_W: write data, port 0.
- we1, input, 1: write enable, port 1 (higher priority).
- waddr1, input, ADDR_W: write address, port 1.
- wdata1, input, DATA_W: write data, port 1.
- re, input, NREAD: per-port read enable.
- raddr, input, NREAD*ADDR_W: read addresses, packed. Port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata, output, NREAD*DATA_W: read data, packed the same way; combinational.
- busy_set, input, 1: mark register busy_addr as having a pending producer.
- busy_addr, input, ADDR_W: target register of busy_set.
- rbusy, output, NREAD: per-port flag; the operand read is not yet valid.

Behaviour:
- FSM states: INIT, RUN.
  - rst high at an edge: state=INIT, sweep pointer ptr=0, all busy bits=0, init_done=0.
  - rst is sampled every edge, so asserting it mid-sweep or in RUN restarts the sweep from ptr 0.
- INIT, rst low:
  - Each edge writes 0 to regs[ptr] and increments ptr.
  - At the edge that clears entry DEPTH-1: state->RUN, init_done<=1.
  - init_done rises exactly DEPTH edges after the first edge with rst low.
  - In INIT, we0, we1 and busy_set are ignored.
- RUN writes, at the rising edge:
  - A write with weN=1 and waddrN!=0 updates regs[waddrN].
  - If both ports write the same nonzero address, port 1's data is stored.
  - Entry 0 is never written.
- Busy scoreboard, updated only in RUN:
  - A write to address A clears busy[A].
  - busy_set with busy_addr!=0 sets busy[busy_addr].
  - If busy_set and a write target the same address at the same edge, set wins.
  - busy[0] is always 0.
- Read port i, combinational, in priority order:
  1. rst=1 or init_done=0 -> 0.
  2. raddr_i==0 -> 0.
  3. re_i==0 -> 0.
  4. we1 && waddr1==raddr_i -> wdata1.
  5. we0 && waddr0==raddr_i -> wdata0.
  6. Otherwise regs[raddr_i].
- rbusy[i] = init_done & re_i & busy[raddr_i] & (raddr_i!=0) & ~(bypass hit from either write port this cycle).
  - A bypassed write completes the producer, so the operand is valid.
  - rbusy is 0 whenever rdata is forced to 0 by rules 1-3.
- Read ports are independent; all NREAD ports may address the same register.
- Output reset values: init_done=0 (registered); rdata=0 and rbusy=0 (combinational, forced by rst).
- No write-to-read latency: a write is visible combinationally in the same cycle via bypass, and from the array from the next cycle on.

Test Plan:
- Reset sweep (ADDR_W=5): hold rst 3 cycles, release -> init_done=0 for 31 edges and 1 after edge 32. Every read during the sweep returns 0 with re=1. After the sweep, reading all 32 regs returns 0.
- Basic write/read: RUN, we0=1 waddr0=5 wdata0=32'h1234_5678 -> same cycle rdata port0 (raddr=5, re=1) = 32'h1234_5678 via bypass. Next cycle with we0=0, still 32'h1234_5678 from the array.
- Dual-write collision: we0=we1=1, both addr=7, wdata0=32'hAAAA_AAAA, wdata1=32'h5555_5555 -> bypass and later array reads both return 32'h5555_5555. A write to addr 0 (wdata=32'hFFFF_FFFF) -> reading r0 returns 0.
- Scoreboard: busy_set addr=9 -> next cycle rbusy[1]=1 for raddr1=9. Cycle with we1 to 9 -> rbusy[1]=0 that cycle (bypass) and after. busy_set and we0 to 9 at the same edge -> busy stays 1.
- Reset mid-operation: write r3=32'hDEAD_BEEF, run sweep to ptr=10, pulse rst -> init_done=0, busy cleared, sweep restarts from 0. After 32 edges, r3 reads 0. we0 issued during INIT has no effect.
- Read enable off: re=0 with raddr=3 holding 32'h0000_0042 and busy[3]=1 -> rdata=0, rbusy=0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write/NREAD-read register file with bypass, busy scoreboard and post-reset clear sweep (clk, rst, init_done, we0/1, waddr0/1, wdata0/1, re, raddr, rdata, busy_set, busy_addr, rbusy)
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      init_done,
  input  logic                      we0,
  input  logic [ADDR_W-1:0]         waddr0,
  input  logic [DATA_W-1:0]         wdata0,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         waddr1,
  input  logic [DATA_W-1:0]         wdata1,
  input  logic [NREAD-1:0]          re,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  input  logic                      busy_set,
  input  logic [ADDR_W-1:0]         busy_addr,
  output logic [NREAD-1:0]          rbusy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ra;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_n;
  logic run, wr0, wr1, hit0, hit1, en;
  always_ff @(posedge clk)
    state <= rst ? INIT : state_n;
  always_comb
    state_n = (state == INIT && ptr == '1) ? RUN : state;
  always_comb begin
    run = state == RUN && !rst;
    wr0 = run && we0 && waddr0 != '0;
    wr1 = run && we1 && waddr1 != '0;
  end
  always_ff @(posedge clk) begin
    ptr       <= rst ? '0 : state == INIT ? ptr + 1'b1 : ptr;
    init_done <= !rst && state_n == RUN;
    busy      <= rst ? '0 : run ? busy_n : busy;
  end
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) regs[ptr] <= '0;
    if (wr0) regs[waddr0] <= wdata0;
    if (wr1) regs[waddr1] <= wdata1;
  end
  always_comb begin
    busy_n = busy;
    if (wr0) busy_n[waddr0] = 1'b0;
    if (wr1) busy_n[waddr1] = 1'b0;
    if (busy_set && busy_addr != '0) busy_n[busy_addr] = 1'b1;
  end
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit0  = 1'b0;
    hit1  = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra   = raddr[i*ADDR_W +: ADDR_W];
      hit1 = we1 && waddr1 == ra;
      hit0 = we0 && waddr0 == ra;
      en   = init_done && !rst && re[i] && ra != '0;
      rdata[i*DATA_W +: DATA_W] = !en ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : regs[ra];
      rbusy[i] = en && busy[ra] && !hit1 && !hit0;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, hand sequences and random stimulus against an array-based reference model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
  logic clk = 0, rst = 1, init_done, we0 = 0, we1 = 0, busy_set = 0;
  logic [AW-1:0] waddr0 = 0, waddr1 = 0, busy_addr = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic [NR-1:0] re = 0, rbusy;
  logic [NR*AW-1:0] raddr = 0;
  logic [NR*DW-1:0] rdata;
  int checks = 0, errors = 0;
  logic [DW-1:0] mregs [DEPTH];
  bit mbusy [DEPTH];
  int cnt = 0;
  bit done = 0;
  typedef struct {
    logic we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
    logic we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
    logic [NR-1:0] re; logic [AW-1:0] ra0, ra1;
    logic bs; logic [AW-1:0] ba;
    logic [DW-1:0] e0, e1; logic [NR-1:0] eb;
  } vec_t;
  vec_t tbl [16];
  always #5 clk = ~clk;
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy)
  );
  function automatic vec_t mk(int w0, int a0, logic [DW-1:0] d0, int w1, int a1, logic [DW-1:0] d1,
                              int r, int r0, int r1, int b, int ba, logic [DW-1:0] e0, logic [DW-1:0] e1, int eb);
    vec_t v;
    v.we0 = w0 != 0; v.wa0 = AW'(a0); v.wd0 = d0;
    v.we1 = w1 != 0; v.wa1 = AW'(a1); v.wd1 = d1;
    v.re = NR'(r); v.ra0 = AW'(r0); v.ra1 = AW'(r1);
    v.bs = b != 0; v.ba = AW'(ba);
    v.e0 = e0; v.e1 = e1; v.eb = NR'(eb);
    return v;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [AW-1:0] port_addr(int i);
    return raddr[i*AW +: AW];
  endfunction
  function automatic bit port_on(int i);
    return done && !rst && re[i] && port_addr(i) != 0;
  endfunction
  function automatic bit bypassed(int i);
    return (we1 && waddr1 == port_addr(i)) || (we0 && waddr0 == port_addr(i));
  endfunction
  function automatic logic [DW-1:0] exp_rd(int i);
    logic [AW-1:0] a = port_addr(i);
    if (!port_on(i)) return 0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return mregs[a];
  endfunction
  function automatic bit exp_rb(int i);
    return port_on(i) && mbusy[port_addr(i)] && !bypassed(i);
  endfunction
  task automatic model_edge();
    if (rst) begin
      cnt = 0;
      done = 0;
      foreach (mbusy[k]) mbusy[k] = 0;
    end else if (!done) begin
      cnt++;
      if (cnt == DEPTH) begin
        done = 1;
        foreach (mregs[k]) mregs[k] = 0;
      end
    end else begin
      if (we0 && waddr0 != 0) begin mregs[waddr0] = wdata0; mbusy[waddr0] = 0; end
      if (we1 && waddr1 != 0) begin mregs[waddr1] = wdata1; mbusy[waddr1] = 0; end
      if (busy_set && busy_addr != 0) mbusy[busy_addr] = 1;
    end
  endtask
  task automatic settle();
    @(negedge clk);
    chk("init_done", init_done, done);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rd(i));
      chk($sformatf("rbusy%0d", i), rbusy[i], exp_rb(i));
    end
  endtask
  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic cyc();
    settle();
    clk_edge();
  endtask
  task automatic idle();
    we0 = 0; we1 = 0; busy_set = 0; re = 0; raddr = 0;
  endtask
  task automatic apply(vec_t v);
    we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    re = v.re; raddr = {v.ra1, v.ra0};
    busy_set = v.bs; busy_addr = v.ba;
  endtask
  initial begin
    foreach (mregs[k]) mregs[k] = 0;
    tbl[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 0,            1, 5, 0, 0, 0, 32'h1234_5678, 0, 0);
    tbl[1]  = mk(0, 0, 0,             0, 0, 0,            3, 5, 5, 0, 0, 32'h1234_5678, 32'h1234_5678, 0);
    tbl[2]  = mk(1, 7, 32'hAAAA_AAAA, 1, 7, 32'h5555_5555, 3, 7, 7, 0, 0, 32'h5555_5555, 32'h5555_5555, 0);
    tbl[3]  = mk(0, 0, 0,             0, 0, 0,            3, 7, 7, 0, 0, 32'h5555_5555, 32'h5555_5555, 0);
    tbl[4]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,            3, 0, 7, 0, 0, 0, 32'h5555_5555, 0);
    tbl[5]  = mk(0, 0, 0,             0, 0, 0,            3, 0, 5, 0, 0, 0, 32'h1234_5678, 0);
    tbl[6]  = mk(0, 0, 0,             0, 0, 0,            2, 0, 9, 1, 9, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,             0, 0, 0,            2, 0, 9, 0, 0, 0, 0, 2);
    tbl[8]  = mk(0, 0, 0,             1, 9, 32'h99,       2, 0, 9, 0, 0, 0, 32'h99, 0);
    tbl[9]  = mk(0, 0, 0,             0, 0, 0,            2, 0, 9, 0, 0, 0, 32'h99, 0);
    tbl[10] = mk(1, 9, 32'h77,        0, 0, 0,            2, 0, 9, 1, 9, 0, 32'h77, 0);
    tbl[11] = mk(0, 0, 0,             0, 0, 0,            2, 0, 9, 0, 0, 0, 32'h77, 2);
    tbl[12] = mk(1, 3, 32'h42,        0, 0, 0,            0, 3, 3, 1, 3, 0, 0, 0);
    tbl[13] = mk(0, 0, 0,             0, 0, 0,            0, 3, 3, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,             0, 0, 0,            1, 3, 3, 0, 0, 32'h42, 0, 1);
    tbl[15] = mk(0, 0, 0,             0, 0, 0,            3, 9, 3, 0, 0, 32'h77, 32'h42, 3);
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    re = '1;
    for (int k = 0; k < DEPTH; k++) begin
      raddr = {AW'($urandom_range(1, DEPTH-1)), AW'($urandom_range(1, DEPTH-1))};
      settle();
      chk("sweep_idone", init_done, 0);
      chk("sweep_rd", rdata, 0);
      clk_edge();
    end
    for (int j = 0; j < DEPTH/2; j++) begin
      raddr = {AW'(2*j+1), AW'(2*j)};
      settle();
      chk("post_idone", init_done, 1);
      chk("post_rd", rdata, 0);
      clk_edge();
    end
    for (int k = 0; k < 16; k++) begin
      apply(tbl[k]);
      settle();
      chk($sformatf("tbl%0d_rd0", k), rdata[DW-1:0], tbl[k].e0);
      chk($sformatf("tbl%0d_rd1", k), rdata[2*DW-1:DW], tbl[k].e1);
      chk($sformatf("tbl%0d_rb", k), rbusy, tbl[k].eb);
      clk_edge();
    end
    idle();
    we0 = 1; waddr0 = 3; wdata0 = 32'hDEAD_BEEF; busy_set = 1; busy_addr = 3;
    cyc();
    idle();
    re = 2'b01; raddr = {AW'(0), AW'(3)};
    settle();
    chk("mid_r3", rdata[DW-1:0], 32'hDEAD_BEEF);
    chk("mid_busy3", rbusy, 2'b01);
    clk_edge();
    rst = 1;
    cyc();
    rst = 0;
    we0 = 1; waddr0 = 3; wdata0 = 32'h1111_1111;
    repeat (10) cyc();
    rst = 1;
    cyc();
    rst = 0;
    settle();
    chk("mid_idone_low", init_done, 0);
    clk_edge();
    repeat (DEPTH-1) cyc();
    we0 = 0;
    settle();
    chk("mid_idone_high", init_done, 1);
    chk("mid_r3_clear", rdata[DW-1:0], 0);
    chk("mid_busy_clear", rbusy, 0);
    clk_edge();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      we0 = $urandom_range(0, 1) != 0;
      we1 = $urandom_range(0, 1) != 0;
      busy_set = $urandom_range(0, 2) == 0;
      waddr0 = AW'($urandom_range(0, n[0] ? 7 : DEPTH-1));
      waddr1 = AW'($urandom_range(0, n[0] ? 7 : DEPTH-1));
      busy_addr = AW'($urandom_range(0, n[0] ? 7 : DEPTH-1));
      wdata0 = $urandom;
      wdata1 = $urandom;
      re = NR'($urandom_range(0, 3));
      raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, n[1] ? 7 : DEPTH-1))};
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
